// File: rtl/dncnt256_if.sv
// dncnt256_if: control, preset and count-output bundle for the 8-bit down counter.
// Clk and MR stay plain ports on the counter itself.
interface dncnt256_if;
  logic       PE;
  logic [7:0] D;
  logic       CEP;
  logic       CET;
  logic       MODE;
  logic [3:0] QH;
  logic [3:0] QL;
  logic       B;
  logic       DONE;

  modport master (
    output PE, D, CEP, CET, MODE,
    input  QH, QL, B, DONE
  );

  modport slave (
    input  PE, D, CEP, CET, MODE,
    output QH, QL, B, DONE
  );
endinterface

// File: rtl/dncnt256.sv
// dncnt256: 8-bit presettable down counter built from two 4-bit nibbles.
// Active-low synchronous load, dual count enables, borrow output gated by CET,
// selectable wrap / stop-at-zero, and a sticky countdown-complete flag.
module dncnt256 (
  input  logic        Clk,
  input  logic        MR,
  dncnt256_if.slave   bus
);

  logic [3:0] r_qh;
  logic [3:0] r_ql;
  logic       r_done;

  logic w_cnt_en;
  logic w_zero;
  logic w_one;

  assign w_cnt_en = bus.CEP & bus.CET;
  assign w_zero   = (r_qh == 4'h0) && (r_ql == 4'h0);
  assign w_one    = (r_qh == 4'h0) && (r_ql == 4'h1);

  // Load / decrement / hold with async clear; high nibble borrows when low nibble is zero.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      r_qh   <= '0;
      r_ql   <= '0;
      r_done <= 1'b0;
    end else if (!bus.PE) begin
      r_qh   <= bus.D[7:4];
      r_ql   <= bus.D[3:0];
      r_done <= 1'b0;
    end else if (w_cnt_en) begin
      if (w_zero) begin
        // At zero only MODE matters: wrap to 0xFF or hold; DONE untouched either way.
        if (!bus.MODE) begin
          r_qh <= '1;
          r_ql <= '1;
        end
      end else begin
        r_ql <= r_ql - 4'h1;
        if (r_ql == 4'h0) begin
          r_qh <= r_qh - 4'h1;
        end
        if (w_one) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.QH   = r_qh;
  assign bus.QL   = r_ql;
  assign bus.DONE = r_done;
  assign bus.B    = bus.CET & w_zero;

endmodule

// File: doc/dncnt256.md
# dncnt256

Synchronous 8-bit presettable down counter: the counting-down counterpart of the team's 256-state up counter. It uses the same nibble-split outputs (QH/QL) and 74HC161-style control inputs, so it drops into the same Counter designs as a countdown timer or modulo-N divider. It parallel-loads a start value, decrements on enabled clocks, and flags terminal count with a borrow output. A mode input selects wrap-around or stop-at-zero, and a sticky DONE flag marks completion of a countdown.

## Interface

Parameters:
- none; width is fixed at 8 bits as two 4-bit nibbles.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- MR  input  1  master reset, asynchronous, active-low.
- PE  input  1  parallel enable, active-low, synchronous; loads D.
- D  input  8  preset value; D[7:4] loads QH and D[3:0] loads QL.
- CEP  input  1  count enable (parallel), active-high.
- CET  input  1  count enable (trickle), active-high; also gates B.
- MODE  input  1  0 = wrap at zero (0x00→0xFF); 1 = stop at zero.
- QH  output  4  high nibble of the count.
- QL  output  4  low nibble of the count.
- B  output  1  borrow / terminal count.
- DONE  output  1  sticky countdown-complete flag.

## Operation

- Count value Q = {QH, QL}, unsigned 8-bit.
- Reset: MR low forces Q = 0x00 and DONE = 0 immediately, independent of Clk. The block holds this state while MR is low.
- Priority at each rising Clk edge while MR is high:
  - PE low: Q ← D and DONE ← 0. CEP, CET and MODE are ignored.
  - PE high, CEP = CET = 1: decrement as follows.
    - Q > 0x01: Q ← Q−1.
    - Q = 0x01: Q ← 0x00 and DONE ← 1.
    - Q = 0x00, MODE = 0: Q ← 0xFF; DONE holds.
    - Q = 0x00, MODE = 1: Q holds at 0x00; DONE holds.
  - Otherwise: Q and DONE hold.
- Nibble borrow: QL decrements every enabled count. QH decrements only when QL = 0x0 at that edge, and QL then becomes 0xF. Both nibbles share Clk; the design uses no derived or gated clocks.
- B = CET & (Q == 0x00). B is combinational and is not gated by CEP, MODE or PE. This allows cascading to a further stage's CET, as with the HC161 TC.
- DONE is cleared only by a load or by reset. A MODE = 0 wrap does not clear it.
- Loading 0x00 leaves DONE = 0. A later enabled count in MODE = 1 then does not set DONE, because DONE sets only on the 0x01→0x00 transition.
- MODE may change at any time. It is sampled only at an edge where Q = 0x00 and counting is enabled.

## Timing

- QH, QL and DONE are registered. They change only on the rising edge of Clk, or asynchronously on the falling edge of MR.
- Load latency: Q = D is visible after the first rising edge with PE low.
- Countdown from a load of N (N ≥ 1) with CEP = CET = 1 held continuously:
  - Q = 0x00 and DONE = 1 after the N-th enabled edge following the load edge.
  - B rises in the same cycle, provided CET = 1.
- B is valid in the same cycle that Q or CET changes, with zero clock latency.
- Reset mid-count: Q goes to 0x00 and DONE to 0 asynchronously, with no completion of the in-flight edge.
  - While MR is low and CET = 1, B = 1.
  - The first edge after MR rises follows the normal priority rules.
- MR deassertion is assumed synchronous to Clk at the system level; this block has no internal synchronizer.

## Test plan

- Reset: MR low mid-count from Q = 0x5A -> Q = 0x00 and DONE = 0 immediately. With CET = 1, B = 1. Q stays 0x00 until MR rises.
- Load, then countdown in MODE = 1: load D = 0x03 -> sequence 0x03, 0x02, 0x01, 0x00, 0x00.
  - DONE rises on the 3rd enabled edge after the load.
  - B = 1 from that edge onward, and Q holds at 0x00 on further enabled edges.
- Wrap in MODE = 0: load 0x01, then 3 enabled edges -> Q = 0x00, then 0xFF, then 0xFE. DONE = 1 from the first edge and stays 1 through the wrap.
- Nibble borrow: load 0x10, then one enabled edge -> QH = 0x0 and QL = 0xF. A further enabled edge -> Q = 0x0E.
- Enables and priority:
  - At Q = 0x40 with CEP = 0 and CET = 1 -> Q holds.
  - At Q = 0x40 with CEP = 1 and CET = 0 -> Q holds.
  - PE low, CEP = CET = 1 and D = 0x77 on the same edge -> Q = 0x77 (load wins) and DONE clears.
- B gating: with Q = 0x00, toggling CET 1→0→1 -> B follows CET combinationally; Q unchanged.
